// File: rtl/tbp_pkg.sv
// tbp_pkg: shared opcodes, FSM states and status flag layout for the
// time_based_processor block and its ALU.
package tbp_pkg;

  // Operation codes, sampled together with operand A
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_FILT  = 3'd5;
  localparam logic [2:0] OP_INV   = 3'd6;
  localparam logic [2:0] OP_CMP   = 3'd7;

  // Bit positions inside status_flags
  localparam int unsigned FLG_ZERO   = 0;
  localparam int unsigned FLG_CARRY  = 1;
  localparam int unsigned FLG_BORROW = 2;
  localparam int unsigned FLG_ERR    = 3;

  // Flag word presented when operand B never arrives
  localparam logic [3:0] FLAGS_ERR = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Unary operations (NOP, INVERT) complete on the operand A beat
  function automatic logic needs_b(input logic [2:0] op);
    return !((op == OP_NOP) || (op == OP_INV));
  endfunction

endpackage

// File: rtl/tbp_alu.sv
// tbp_alu: purely combinational 8-bit operand ALU producing a 16-bit result
// and the zero / carry / borrow flags. The error flag is never set here.
module tbp_alu
  import tbp_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic [8:0]  sum;
  logic [15:0] prod;
  logic [7:0]  lost_mask;

  // Shared arithmetic terms used by several operations
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    prod      = {8'h00, a} * {8'h00, b};
    // Bits of A that fall off the bottom of a right shift by b[2:0]
    lost_mask = ~(8'hFF << b[2:0]);
  end

  // Operation select and flag generation
  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_NOP: result = {8'h00, a};
      OP_ADD: begin
        result           = {7'b0, sum};
        flags[FLG_CARRY] = sum[8];
      end
      OP_SUB: begin
        // 16-bit subtraction of zero-extended operands yields the
        // sign-extended two's complement difference directly
        result            = {8'h00, a} - {8'h00, b};
        flags[FLG_BORROW] = (a < b);
      end
      OP_MUL: begin
        result           = prod;
        flags[FLG_CARRY] = |prod[15:8];
      end
      OP_SHIFT: begin
        if (b[3]) begin
          result           = {8'h00, a >> b[2:0]};
          flags[FLG_CARRY] = |(a & lost_mask);
        end else begin
          result = {8'h00, a} << b[2:0];
        end
      end
      OP_FILT: result = {8'h00, sum[8:1]};
      OP_INV:  result = {8'h00, ~a};
      OP_CMP: begin
        if (a > b) begin
          result = 16'h0001;
        end else if (a < b) begin
          result            = 16'h0002;
          flags[FLG_BORROW] = 1'b1;
        end else begin
          result = 16'h0004;
        end
      end
      default: result = '0;
    endcase
    flags[FLG_ZERO] = (result == 16'h0000);
  end

endmodule

// File: rtl/time_based_processor.sv
// time_based_processor: byte-serial operand processor. Operand A and the
// opcode arrive on one data_valid beat, operand B (binary ops only) on a
// later beat; the result appears EXEC_CYCLES+1 edges after the final
// operand is captured and is held, with data_ready high, until the next
// operation starts.
// Optional feature: define TBP_TIMEOUT_EN to abandon an operation whose
// operand B does not arrive within TIMEOUT_CYCLES cycles (error flag set).
module time_based_processor
  import tbp_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic [2:0]  opcode,
  input  logic        data_valid,
  output logic [15:0] data_out,
  output logic        data_ready,
  output logic [3:0]  status_flags
);

  localparam int unsigned CNT_MAX = (EXEC_CYCLES > TIMEOUT_CYCLES) ? EXEC_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] EXEC_LAST = CW'(EXEC_CYCLES);
`ifdef TBP_TIMEOUT_EN
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  cnt;
  logic [7:0]     a_reg;
  logic [7:0]     b_reg;
  logic [2:0]     op_reg;
  logic [15:0]    alu_result;
  logic [3:0]     alu_flags;

  logic           load_a;
  logic           load_b;
  logic           load_res;
  logic           load_err;
  logic           cnt_clr;

  tbp_alu u_alu (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath load strobes; cnt restarts on every state entry
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_res   = 1'b0;
    load_err   = 1'b0;
    cnt_clr    = 1'b1;
    case (state)
      IDLE, DONE: begin
        if (data_valid) begin
          load_a     = 1'b1;
          next_state = needs_b(opcode) ? WAIT_B : EXEC;
        end
      end
      WAIT_B: begin
        if (data_valid) begin
          load_b     = 1'b1;
          next_state = EXEC;
        end
`ifdef TBP_TIMEOUT_EN
        else if (cnt == WAIT_LAST) begin
          load_err   = 1'b1;
          next_state = DONE;
        end else begin
          cnt_clr = 1'b0;
        end
`endif
      end
      EXEC: begin
        // cnt runs 0..EXEC_CYCLES, so the result register loads on the
        // (EXEC_CYCLES+1)th edge after the final operand capture
        if (cnt == EXEC_LAST) begin
          load_res   = 1'b1;
          next_state = DONE;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, cycle counter and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      data_out     <= '0;
      status_flags <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (load_a) begin
        a_reg  <= data_in;
        op_reg <= opcode;
        b_reg  <= '0;
      end
      if (load_b) begin
        b_reg <= data_in;
      end
      if (load_res) begin
        data_out     <= alu_result;
        status_flags <= alu_flags;
      end
      if (load_err) begin
        data_out     <= '0;
        status_flags <= FLAGS_ERR;
      end
    end
  end

  // Result is valid exactly while parked in DONE
  always_comb begin
    data_ready = (state == DONE);
  end

endmodule

// File: tb/tb_time_based_processor.sv
// tb_time_based_processor: directed vectors with a scoreboard. Stimulus
// pushes the expected result, flags and latency; a monitor pops on each
// rising data_ready and compares.
module tb_time_based_processor;

  localparam int unsigned EXEC = 2;
  localparam int unsigned TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [2:0]  opcode = 3'd0;
  logic        data_valid = 1'b0;
  logic [15:0] data_out;
  logic        data_ready;
  logic [3:0]  status_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_ready = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    int          cap;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  time_based_processor #(
    .EXEC_CYCLES    (EXEC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .opcode       (opcode),
    .data_valid   (data_valid),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .status_flags (status_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard
  always @(negedge clk) begin
    if (!rst && data_ready && !prev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got data_out %h with no pending op", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "/data"}, {16'h0, data_out}, {16'h0, e.d});
        chk({e.name, "/flags"}, {28'h0, status_flags}, {28'h0, e.f});
        chk({e.name, "/latency"}, cyc - e.cap, e.lat);
      end
    end
    prev_ready = data_ready;
  end

  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s/ready_wait: got data_ready 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] d, input logic [3:0] f,
                        input int gap, input bit hold);
    bit ok;
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = op;
    data_in    = a;
    @(negedge clk);
    chk({name, "/ready_clear"}, {31'h0, data_ready}, 32'h0);
    if (op != 3'd0 && op != 3'd6) begin
      if (gap > 0) begin
        data_valid = 1'b0;
        data_in    = 8'h5A;
        repeat (gap) @(negedge clk);
      end
      data_valid = 1'b1;
      data_in    = b;
      opcode     = 3'd7;
      @(negedge clk);
    end
    sb.push_back('{d: d, f: f, cap: cyc, lat: int'(EXEC + 1), name: name});
    if (hold) begin
      data_in = 8'hEE;
      opcode  = 3'd1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    wait_ready(name, ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      chk({name, "/hold_ready"}, {31'h0, data_ready}, 32'h1);
      chk({name, "/hold_data"}, {16'h0, data_out}, {16'h0, d});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("reset/data_out", {16'h0, data_out}, 32'h0);
    chk("reset/ready", {31'h0, data_ready}, 32'h0);
    chk("reset/flags", {28'h0, status_flags}, 32'h0);
    rst = 1'b0;

    run_op("nop_55",    3'd0, 8'h55, 8'h00, 16'h0055, 4'b0000, 0, 1'b0);
    run_op("inv_aa",    3'd6, 8'hAA, 8'h00, 16'h0055, 4'b0000, 0, 1'b1);
    run_op("add_23_45", 3'd1, 8'h23, 8'h45, 16'h0068, 4'b0000, 0, 1'b0);
    run_op("add_ff_01", 3'd1, 8'hFF, 8'h01, 16'h0100, 4'b0010, 2, 1'b0);
    run_op("add_00_00", 3'd1, 8'h00, 8'h00, 16'h0000, 4'b0001, 0, 1'b1);
    run_op("mul_05_04", 3'd3, 8'h05, 8'h04, 16'h0014, 4'b0000, 0, 1'b0);
    run_op("mul_23_45", 3'd3, 8'h23, 8'h45, 16'h096F, 4'b0010, 0, 1'b0);
    run_op("mul_ff_ff", 3'd3, 8'hFF, 8'hFF, 16'hFE01, 4'b0010, 0, 1'b0);
    run_op("sub_45_23", 3'd2, 8'h45, 8'h23, 16'h0022, 4'b0000, 3, 1'b0);
    run_op("sub_23_45", 3'd2, 8'h23, 8'h45, 16'hFFDE, 4'b0100, 0, 1'b0);
    run_op("sub_23_23", 3'd2, 8'h23, 8'h23, 16'h0000, 4'b0001, 0, 1'b0);
    run_op("filt_aa_55", 3'd5, 8'hAA, 8'h55, 16'h007F, 4'b0000, 0, 1'b0);
    run_op("shl_05_01", 3'd4, 8'h05, 8'h01, 16'h000A, 4'b0000, 0, 1'b0);
    run_op("shl_ff_07", 3'd4, 8'hFF, 8'h07, 16'h7F80, 4'b0000, 0, 1'b0);
    run_op("shr_08_09", 3'd4, 8'h08, 8'h09, 16'h0004, 4'b0000, 0, 1'b0);
    run_op("shr_03_0a", 3'd4, 8'h03, 8'h0A, 16'h0000, 4'b0011, 0, 1'b0);
    run_op("cmp_23_22", 3'd7, 8'h23, 8'h22, 16'h0001, 4'b0000, 0, 1'b0);
    run_op("cmp_22_23", 3'd7, 8'h22, 8'h23, 16'h0002, 4'b0100, 0, 1'b0);
    run_op("cmp_23_23", 3'd7, 8'h23, 8'h23, 16'h0004, 4'b0000, 0, 1'b1);
    run_op("inv_ff",    3'd6, 8'hFF, 8'h00, 16'h0000, 4'b0001, 0, 1'b0);

    // Abort an ADD while it waits for operand B
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = 3'd1;
    data_in    = 8'h11;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort/data_out", {16'h0, data_out}, 32'h0);
    chk("abort/ready", {31'h0, data_ready}, 32'h0);
    chk("abort/flags", {28'h0, status_flags}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // A beat after reset must be taken as a fresh operand A, not as B
    run_op("post_abort_nop", 3'd0, 8'h22, 8'h00, 16'h0022, 4'b0000, 0, 1'b0);
    run_op("post_abort_add", 3'd1, 8'h11, 8'h22, 16'h0033, 4'b0000, 0, 1'b0);

`ifdef TBP_TIMEOUT_EN
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = 3'd1;
    data_in    = 8'h40;
    @(negedge clk);
    data_valid = 1'b0;
    sb.push_back('{d: 16'h0000, f: 4'b1000, cap: cyc, lat: int'(TO), name: "timeout"});
    wait_ready("timeout", ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      chk("timeout/hold_ready", {31'h0, data_ready}, 32'h1);
    end
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
